clock_tick_scheduler: RTL and testbench

Sequences the BCD 12-hour clock datapath through its one-bit `ena` advance input.
- Divides `clk` down to a 1 Hz advance strobe for normal timekeeping.
- Serves user "+1 minute" and "+1 hour" set requests by issuing bursts of consecutive `ena` pulses (60 or 3600), so the datapath needs no load port.
- Sits between the debounced button/mode logic and the clock counter.

---
 rtl/clock_tick_scheduler_pkg.sv | 18 +
 rtl/clock_tick_scheduler_if.sv | 21 ++
 rtl/clock_tick_scheduler_sec_prescaler.sv | 38 +++
 rtl/clock_tick_scheduler.sv | 100 ++++++++++
 tb/tb_clock_tick_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_tick_scheduler_pkg.sv
// Shared types and constants for the clock tick scheduler.
// Holds the FSM state type, default burst lengths and the rem-width helper.
package clock_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int BURST_MIN_DEF = 60;
  localparam int BURST_HR_DEF  = 3600;

  // Longest burst plus one catch-up pulse per tick that can land inside it.
  function automatic int rem_width(input int burst_hr, input int clk_hz);
    return $clog2(burst_hr + burst_hr / clk_hz + 2);
  endfunction

endpackage

// File: rtl/clock_tick_scheduler_if.sv
// Request/strobe bundle between the button logic, the scheduler and the clock datapath.
// master = request side (button/mode logic), slave = scheduler.
interface clock_tick_scheduler_if;
  logic run_en;
  logic btn_min;
  logic btn_hr;
  logic ena;
  logic sec_tick;
  logic busy;
  logic req_drop;

  modport master (
    output run_en, btn_min, btn_hr,
    input  ena, sec_tick, busy, req_drop
  );

  modport slave (
    input  run_en, btn_min, btn_hr,
    output ena, sec_tick, busy, req_drop
  );
endinterface

// File: rtl/clock_tick_scheduler_sec_prescaler.sv
// Divides clk to a one-second wrap strobe; the count holds (not clears) while stopped.
// wrap_o is combinational for the scheduler FSM; sec_tick_o is its registered copy.
module sec_prescaler #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run_en_i,
  output logic wrap_o,
  output logic sec_tick_o
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sec_tick_q;

  assign wrap_o     = run_en_i && (cnt_q == CNT_MAX);
  assign sec_tick_o = sec_tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o)        cnt_d = '0;
    else if (run_en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sec_tick_q <= wrap_o;
    end
  end

endmodule

// File: rtl/clock_tick_scheduler.sv
// Drives the clock datapath's ena: 1 Hz ticks normally, 60/3600-pulse bursts for set requests.
// Build option TICK_CATCHUP_EN: seconds ticking during a burst lengthen it instead of being lost.
module clock_tick_scheduler
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BURST_MIN = BURST_MIN_DEF,
  parameter int BURST_HR  = BURST_HR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  clock_tick_scheduler_if.slave  bus
);

  localparam int REM_W = rem_width(BURST_HR, CLK_HZ);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] catch_inc;
  logic [REM_W-1:0] rem_sum;
  logic             ena_q, ena_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             wrap;

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .run_en_i   (bus.run_en),
    .wrap_o     (wrap),
    .sec_tick_o (bus.sec_tick)
  );

`ifdef TICK_CATCHUP_EN
  assign catch_inc = REM_W'(wrap);
`else
  assign catch_inc = '0;
`endif

  // rem counts pulses still owed after the one currently on ena.
  assign rem_sum = rem_q + catch_inc;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ena_d   = 1'b0;
    busy_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ena_d = wrap;
        if (bus.btn_hr) begin
          state_d = BURST;
          rem_d   = REM_W'(BURST_HR - 1) + catch_inc;
          ena_d   = 1'b1;
          busy_d  = 1'b1;
          drop_d  = bus.btn_min;
        end else if (bus.btn_min) begin
          state_d = BURST;
          rem_d   = REM_W'(BURST_MIN - 1) + catch_inc;
          ena_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      BURST: begin
        drop_d = bus.btn_min | bus.btn_hr;
        if (rem_sum == '0) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d  = rem_sum - REM_W'(1);
          ena_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ena      = ena_q;
  assign bus.busy     = busy_q;
  assign bus.req_drop = drop_q;

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Self-checking bench for clock_tick_scheduler (CLK_HZ=4), reference kept as an "owed pulses" model.
// Honours TICK_CATCHUP_EN the same way the design build does.
module tb_clock_tick_scheduler;

  localparam int HZ   = 4;
  localparam int NMIN = 60;
  localparam int NHR  = 3600;
`ifdef TICK_CATCHUP_EN
  localparam bit CATCH = 1'b1;
`else
  localparam bit CATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  clock_tick_scheduler_if bus();

  always #5 clk = ~clk;

  clock_tick_scheduler #(.CLK_HZ(HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: seconds phase, pulses still owed, and expected visible outputs.
  int m_phase = 0;
  int m_left  = 0;
  bit m_ena = 0, m_tick = 0, m_busy = 0, m_drop = 0;

  task automatic model_update(input bit rst, input bit run, input bit bmin, input bit bhr);
    bit w;
    if (rst) begin
      m_phase = 0; m_left = 0;
      m_ena = 0; m_tick = 0; m_busy = 0; m_drop = 0;
    end else begin
      w = run && (m_phase == HZ - 1);
      m_drop = 0;
      if (m_busy) begin
        m_drop = bmin | bhr;
        if (CATCH && w) m_left++;
        if (m_left > 0) begin
          m_ena = 1; m_busy = 1; m_left--;
        end else begin
          m_ena = 0; m_busy = 0;
        end
      end else if (bmin | bhr) begin
        m_left = (bhr ? NHR : NMIN) + ((CATCH && w) ? 1 : 0) - 1;
        m_drop = bhr && bmin;
        m_ena = 1; m_busy = 1;
      end else begin
        m_ena = w; m_busy = 0;
      end
      m_tick = w;
      if (run) m_phase = (m_phase + 1) % HZ;
    end
  endtask

  task automatic step(input bit rst, input bit run, input bit bmin, input bit bhr);
    reset = rst; bus.run_en = run; bus.btn_min = bmin; bus.btn_hr = bhr;
    @(posedge clk);
    model_update(rst, run, bmin, bhr);
    @(negedge clk);
  endtask

  // Burst length from the rules: N plus every tick seen from the accept cycle to the last pulse.
  function automatic int expected_len(input int p, input bit run, input int n);
    int len, nxt, cnt;
    len = n;
    for (int it = 0; it < 100; it++) begin
      cnt = 0;
      for (int k = 0; k <= len; k++)
        if (run && ((p + k) % HZ == HZ - 1)) cnt++;
      nxt = n + (CATCH ? cnt : 0);
      if (nxt == len) break;
      len = nxt;
    end
    return len;
  endfunction

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    checks++; if (bus.ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", bus.ena); end
    checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", bus.sec_tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.req_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", bus.req_drop); end
  endtask

  task automatic test_free_run();
    int first = -1;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 0);
      if (first < 0 && bus.sec_tick === 1'b1) first = i;
      checks++;
      if (bus.ena !== m_ena || bus.sec_tick !== m_tick || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL free_run cyc %0d ena=%b/%b tick=%b/%b busy=%b/0", i, bus.ena, m_ena, bus.sec_tick, m_tick, bus.busy);
      end
    end
    checks++; if (first !== HZ) begin errors++; $display("FAIL first_tick got cycle %0d want %0d", first, HZ); end
  endtask

  task automatic test_min_burst_stopped();
    int p, len, ticks, wait_n;
    p = m_phase; len = 0; ticks = 0;
    step(0, 0, 1, 0);
    while (bus.ena === 1'b1 && len < 5000) begin
      len++;
      if (bus.sec_tick === 1'b1) ticks++;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL min_busy pulse %0d got %b want 1", len, bus.busy); end
      step(0, 0, 0, 0);
    end
    checks++; if (len !== NMIN) begin errors++; $display("FAIL min_len got %0d want %0d", len, NMIN); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL min_busy_end got %b want 0", bus.busy); end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL min_ticks got %0d want 0", ticks); end
    wait_n = 0;
    do begin step(0, 1, 0, 0); wait_n++; end while (bus.sec_tick !== 1'b1 && wait_n < 20);
    checks++; if (wait_n !== HZ - p) begin errors++; $display("FAIL held_phase got %0d want %0d", wait_n, HZ - p); end
  endtask

  task automatic test_burst_running();
    int p, len, want;
    p = m_phase; len = 0;
    want = expected_len(p, 1'b1, NMIN);
    step(0, 1, 1, 0);
    while (bus.ena === 1'b1 && len < 5000) begin
      len++;
      checks++;
      if (bus.sec_tick !== m_tick || bus.busy !== m_busy || bus.ena !== m_ena) begin
        errors++;
        $display("FAIL run_burst pulse %0d tick=%b/%b busy=%b/%b", len, bus.sec_tick, m_tick, bus.busy, m_busy);
      end
      step(0, 1, 0, 0);
    end
    checks++; if (len !== want) begin errors++; $display("FAIL run_burst_len got %0d want %0d", len, want); end
  endtask

  task automatic test_dual_request();
    int len, drops;
    len = 0; drops = 0;
    step(0, 0, 1, 1);
    checks++; if (bus.req_drop !== 1'b1) begin errors++; $display("FAIL dual_drop got %b want 1", bus.req_drop); end
    while (bus.ena === 1'b1 && len < 5000) begin
      len++;
      step(0, 0, len == 10, 0);
      if (bus.req_drop === 1'b1) drops++;
    end
    checks++; if (len !== NHR) begin errors++; $display("FAIL dual_len got %0d want %0d", len, NHR); end
    checks++; if (drops !== 1) begin errors++; $display("FAIL mid_burst_drops got %0d want 1", drops); end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    step(0, 0, 1, 0);
    while (!(m_busy && m_left == 0) && guard < 5000) begin step(0, 0, 0, 0); guard++; end
    step(0, 0, 1, 0);
    checks++;
    if (bus.req_drop !== 1'b1 || bus.ena !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL last_cycle_req drop=%b ena=%b busy=%b want 1 0 0", bus.req_drop, bus.ena, bus.busy);
    end
    step(0, 0, 1, 0);
    checks++;
    if (bus.req_drop !== 1'b0 || bus.ena !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL first_idle_req drop=%b ena=%b busy=%b want 0 1 1", bus.req_drop, bus.ena, bus.busy);
    end
    guard = 0;
    while (bus.busy === 1'b1 && guard < 5000) begin step(0, 0, 0, 0); guard++; end
  endtask

  task automatic test_random();
    bit run = 1'b1;
    bit rst, bmin, bhr;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      rst  = ($urandom_range(0, 999) == 0);
      bmin = ($urandom_range(0, 39) == 0);
      bhr  = ($urandom_range(0, 399) == 0);
      step(rst, run, bmin, bhr);
      checks++;
      if (bus.ena !== m_ena || bus.sec_tick !== m_tick || bus.busy !== m_busy || bus.req_drop !== m_drop) begin
        errors++;
        $display("FAIL random cyc %0d ena=%b/%b tick=%b/%b busy=%b/%b drop=%b/%b", i,
                 bus.ena, m_ena, bus.sec_tick, m_tick, bus.busy, m_busy, bus.req_drop, m_drop);
      end
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    step(0, 0, 0, 1);
    for (int i = 1; i < 100; i++) step(0, 0, 0, 0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pre_abort_busy got %b want 1", bus.busy); end
    step(1, 0, 0, 0);
    checks++;
    if (bus.ena !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort ena=%b busy=%b want 0 0", bus.ena, bus.busy);
    end
    step(0, 0, 0, 0);
    checks++;
    if (bus.ena !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL after_abort ena=%b busy=%b want 0 0", bus.ena, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_min_burst_stopped();
    test_burst_running();
    test_dual_request();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
